// File: rtl/adc_pulse_tx_sched.sv
// adc_pulse_tx_sched: per sample_tick, runs one ADC conversion, snapshots two
// pulse-event counters and streams a 7-byte checksummed frame to the UART TX.
module adc_pulse_tx_sched #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         ADC_TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tick,
  output logic        start,
  input  logic        done,
  input  logic [11:0] data1,
  input  logic [11:0] data2,
  input  logic        Pulse1_in,
  input  logic        Pulse2_in,
  output logic        TxD_start,
  output logic [7:0]  TxD_data,
  input  logic        TxD_busy,
  output logic        overrun
);

  localparam int            TW       = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ADC_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_LOAD, S_SEND, S_GAP} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_start;
  logic            r_txd_start;
  logic [7:0]      r_txd_data;
  logic            r_overrun;
  logic [TW-1:0]   r_tmo;
  logic [11:0]     r_ch1;
  logic [11:0]     r_ch2;
  logic [7:0]      r_frame [7];
  logic [2:0]      r_idx;

  logic            w_load;
  logic            w_send_fire;
  logic            w_tmo_hit;
  logic [1:0]      w_pulse_in;
  logic [1:0]      w_edge;
  logic [1:0][7:0] w_pcnt;
  logic [7:0]      w_b1;
  logic [7:0]      w_b2;
  logic [7:0]      w_b3;
  logic [7:0]      w_csum;

  assign w_load      = (r_state == S_LOAD);
  assign w_send_fire = (r_state == S_SEND) && !TxD_busy;
  assign w_tmo_hit   = (r_tmo == TMO_LAST);
  assign w_pulse_in  = {Pulse2_in, Pulse1_in};

  assign w_b1   = r_ch1[11:4];
  assign w_b2   = {r_ch1[3:0], r_ch2[11:8]};
  assign w_b3   = r_ch2[7:0];
  assign w_csum = HEADER ^ w_b1 ^ w_b2 ^ w_b3 ^ w_pcnt[0] ^ w_pcnt[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pulse
      logic       r_q;
      logic [7:0] r_cnt;

      assign w_edge[gi] = w_pulse_in[gi] & ~r_q;
      assign w_pcnt[gi] = r_cnt;

      // Saturating rising-edge counter; an edge on the snapshot cycle seeds the next interval.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_q   <= 1'b0;
          r_cnt <= 8'd0;
        end else begin
          r_q <= w_pulse_in[gi];
          if (w_load) begin
            r_cnt <= {7'd0, w_edge[gi]};
          end else if (w_edge[gi] && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      end
    end
  endgenerate

  // Next-state decode; done is masked in the start cycle because it may be stale.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (sample_tick) w_state_next = S_CONV;
      S_CONV: if (!r_start && (done || w_tmo_hit)) w_state_next = S_LOAD;
      S_LOAD: w_state_next = S_SEND;
      S_SEND: if (!TxD_busy) w_state_next = S_GAP;
      S_GAP:  w_state_next = (r_idx == 3'd6) ? S_IDLE : S_SEND;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: strobes, ADC capture, frame build and byte sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start     <= 1'b0;
      r_txd_start <= 1'b0;
      r_txd_data  <= 8'd0;
      r_overrun   <= 1'b0;
      r_tmo       <= '0;
      r_ch1       <= 12'd0;
      r_ch2       <= 12'd0;
      r_idx       <= 3'd0;
      for (int i = 0; i < 7; i++) r_frame[i] <= 8'd0;
    end else begin
      r_start     <= (r_state == S_IDLE) && sample_tick;
      r_txd_start <= w_send_fire;
      if (w_send_fire) r_txd_data <= r_frame[r_idx];
      if (sample_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (sample_tick) r_tmo <= '0;
        end
        S_CONV: begin
          r_tmo <= r_tmo + 1'b1;
          if (!r_start) begin
            if (done) begin
              r_ch1 <= data1;
              r_ch2 <= data2;
            end else if (w_tmo_hit) begin
              r_ch1 <= 12'hFFF;
              r_ch2 <= 12'hFFF;
            end
          end
        end
        S_LOAD: begin
          r_frame[0] <= HEADER;
          r_frame[1] <= w_b1;
          r_frame[2] <= w_b2;
          r_frame[3] <= w_b3;
          r_frame[4] <= w_pcnt[0];
          r_frame[5] <= w_pcnt[1];
          r_frame[6] <= w_csum;
          r_idx      <= 3'd0;
        end
        S_GAP: begin
          if (r_idx != 3'd6) r_idx <= r_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign start     = r_start;
  assign TxD_start = r_txd_start;
  assign TxD_data  = r_txd_data;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_adc_pulse_tx_sched.sv
// Directed bench for adc_pulse_tx_sched with a simple UART busy model.
module tb_adc_pulse_tx_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_tick = 1'b0;
  logic        done = 1'b0;
  logic [11:0] data1 = 12'd0;
  logic [11:0] data2 = 12'd0;
  logic        Pulse1_in = 1'b0;
  logic        Pulse2_in = 1'b0;
  logic        bp_hold = 1'b0;
  logic        start;
  logic        TxD_start;
  logic [7:0]  TxD_data;
  logic        TxD_busy;
  logic        overrun;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int start_dbl = 0;
  int busy_viol = 0;
  int done_cyc = 0;
  logic start_prev = 1'b0;
  logic [7:0] byte_q[$];
  int strobe_q[$];

  adc_pulse_tx_sched #(
    .HEADER(8'hA5),
    .ADC_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_tick(sample_tick),
    .start(start),
    .done(done),
    .data1(data1),
    .data2(data2),
    .Pulse1_in(Pulse1_in),
    .Pulse2_in(Pulse2_in),
    .TxD_start(TxD_start),
    .TxD_data(TxD_data),
    .TxD_busy(TxD_busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy for 10 cycles after each accepted strobe.
  always @(posedge clk) begin
    if (TxD_start) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign TxD_busy = (busy_cnt != 0) || bp_hold;

  // Monitor on the falling edge: log strobes and bytes.
  always @(negedge clk) begin
    if (start) begin
      start_cnt++;
      start_cyc = cyc;
      if (start_prev) start_dbl++;
    end
    start_prev = start;
    if (TxD_start) begin
      byte_q.push_back(TxD_data);
      strobe_q.push_back(cyc);
      if (TxD_busy) busy_viol++;
      $display("tx byte idx=%0d data=%02h cycle=%0d", byte_q.size() - 1, TxD_data, cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic wait_bytes(input int n);
    int k = 0;
    while (byte_q.size() < n && k < 1000) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (byte_q.size() < n) check_eq("byte_wait_timeout", 32'(byte_q.size()), 32'(n));
  endtask

  task automatic adc_respond(input int delay, input logic [11:0] d1, input logic [11:0] d2,
                             input bit pulse_on_load);
    int k = 0;
    while (!start && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!start) check_eq("start_wait_timeout", 32'(start), 32'd1);
    repeat (delay) @(negedge clk);
    done = 1'b1;
    data1 = d1;
    data2 = d2;
    done_cyc = cyc;
    @(negedge clk);
    done = 1'b0;
    data1 = 12'h000;
    data2 = 12'h000;
    if (pulse_on_load) Pulse1_in = 1'b1;
    @(negedge clk);
    Pulse1_in = 1'b0;
  endtask

  task automatic compare_frame(input string name, input logic [55:0] exp);
    logic [7:0] got;
    check_eq({name, "_count"}, 32'(byte_q.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      got = (byte_q.size() > i) ? byte_q[i] : 8'hXX;
      check_eq($sformatf("%s_B%0d", name, i), 32'(got), 32'(exp[55 - 8*i -: 8]));
    end
  endtask

  // delay=0 means the ADC never answers, so the timeout path is taken.
  task automatic run_frame(input string name, input int delay, input logic [11:0] d1,
                           input logic [11:0] d2, input bit pl, input logic [55:0] exp);
    byte_q.delete();
    strobe_q.delete();
    tick();
    if (delay > 0) adc_respond(delay, d1, d2, pl);
    wait_bytes(7);
    repeat (30) @(negedge clk);
    #1;
    compare_frame(name, exp);
    if (strobe_q.size() > 0) begin
      if (delay > 0) check_eq({name, "_latency"}, 32'(strobe_q[0] - done_cyc), 32'd3);
      else check_eq({name, "_tmo_len"}, 32'(strobe_q[0] - start_cyc), 32'd18);
    end
  endtask

  initial begin
    int base;
    int rel_cyc;
    bit held_ok;

    // Reset state
    repeat (5) @(negedge clk);
    check_eq("rst_start", 32'(start), 32'd0);
    check_eq("rst_txd_start", 32'(TxD_start), 32'd0);
    check_eq("rst_txd_data", 32'(TxD_data), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Basic frame
    run_frame("basic", 5, 12'h123, 12'hABC, 1'b0, 56'hA5_12_3A_BC_00_00_31);
    check_eq("basic_starts", 32'(start_cnt), 32'd1);

    // Pulse counting with saturation and an edge on the snapshot cycle
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      Pulse2_in = 1'b1;
      Pulse1_in = (i < 3);
      @(negedge clk);
      Pulse2_in = 1'b0;
      Pulse1_in = 1'b0;
    end
    run_frame("pulse", 2, 12'h000, 12'h000, 1'b1, 56'hA5_00_00_00_03_FF_59);
    run_frame("pulse2", 2, 12'h000, 12'h000, 1'b0, 56'hA5_00_00_00_01_00_A4);

    // ADC timeout
    run_frame("tmo", 0, 12'h000, 12'h000, 1'b0, 56'hA5_FF_FF_FF_00_00_5A);

    // Overrun during SEND
    base = start_cnt;
    byte_q.delete();
    strobe_q.delete();
    tick();
    adc_respond(3, 12'h123, 12'hABC, 1'b0);
    wait_bytes(2);
    tick();
    check_eq("ovr_set", 32'(overrun), 32'd1);
    wait_bytes(7);
    repeat (30) @(negedge clk);
    check_eq("ovr_no_restart", 32'(start_cnt), 32'(base + 1));
    compare_frame("ovr_frame", 56'hA5_12_3A_BC_00_00_31);
    run_frame("ovr_next", 3, 12'h123, 12'hABC, 1'b0, 56'hA5_12_3A_BC_00_00_31);
    check_eq("ovr_next_starts", 32'(start_cnt), 32'(base + 2));
    check_eq("ovr_sticky", 32'(overrun), 32'd1);

    // Back-pressure
    byte_q.delete();
    strobe_q.delete();
    tick();
    adc_respond(2, 12'h5A5, 12'h0F0, 1'b0);
    wait_bytes(2);
    bp_hold = 1'b1;
    held_ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      #1;
      if (byte_q.size() != 2 || TxD_start || TxD_data != 8'h5A) held_ok = 1'b0;
    end
    check_eq("bp_hold", 32'(held_ok), 32'd1);
    rel_cyc = cyc;
    bp_hold = 1'b0;
    wait_bytes(7);
    repeat (30) @(negedge clk);
    if (strobe_q.size() > 2) check_eq("bp_resume", 32'(strobe_q[2] - rel_cyc), 32'd1);
    else check_eq("bp_resume_missing", 32'(strobe_q.size()), 32'd3);
    compare_frame("bp", 56'hA5_5A_50_F0_00_00_5F);

    // Reset mid-frame during B3
    byte_q.delete();
    strobe_q.delete();
    tick();
    adc_respond(2, 12'h123, 12'hABC, 1'b0);
    wait_bytes(4);
    check_eq("mid_B3", 32'(TxD_data), 32'h0BC);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_eq("mid_rst_start", 32'(start), 32'd0);
    check_eq("mid_rst_txd_start", 32'(TxD_start), 32'd0);
    check_eq("mid_rst_txd_data", 32'(TxD_data), 32'd0);
    check_eq("mid_rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("mid_no_more_bytes", 32'(byte_q.size()), 32'd4);
    run_frame("after_rst", 4, 12'h123, 12'hABC, 1'b0, 56'hA5_12_3A_BC_00_00_31);

    check_eq("start_single_cycle", 32'(start_dbl), 32'd0);
    check_eq("no_strobe_when_busy", 32'(busy_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
